reg_bank_hs: RTL and testbench
==============================

# reg_bank_hs

Parametrised successor to the team's four-register test DUT. It provides NUM_REGS configurable registers with byte-strobed writes and per-register read-only slots that mirror hardware status. Accesses use a valid/ready request channel and a response channel that can be backpressured. Out-of-range and illegal accesses return an error response. It is the standard register target for the UVM register-model exercises.

## Interface
- NUM_REGS, 8: number of registers; offset addresses 0..NUM_REGS-1.
- DATA_W, 32: register width; must be a multiple of 8.
- ADDR_W, 4: address width; 2**ADDR_W >= NUM_REGS.
- RO_MASK, 8'h80: NUM_REGS bits; bit i=1 makes register i read-only, mirroring a hw_status slice.
- RESET_VAL, 0: DATA_W reset value of every read/write register.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  register offset.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  byte enables for writes; ignored on reads.
- hw_status  in  NUM_REGS*DATA_W  packed status; slice i is used only when RO_MASK[i]=1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  access error.

## Operation
- FSM with two states.
  - IDLE: req_ready=1, rsp_valid=0.
  - RESP: req_ready=0, rsp_valid=1.
- Accept occurs when req_valid && req_ready. It causes IDLE->RESP. In RESP, rsp_valid && rsp_ready causes RESP->IDLE.
- Error conditions, evaluated at accept:
  - req_addr >= NUM_REGS, for read or write.
  - Write to a register with RO_MASK bit set.
  - An error causes no state change in any register, and sets rsp_rdata=0, rsp_err=1.
- Legal write: for each byte b with req_strb[b]=1, reg[addr][8b+7:8b] <= req_wdata byte b. Bytes with strobe 0 are unchanged. An all-zero strobe is legal and changes nothing, with rsp_err=0. Write response has rsp_rdata=0.
- Legal read of a read/write register: rsp_rdata is the register value at the accept edge, before any update that edge.
- Legal read of a read-only register: rsp_rdata is the hw_status slice sampled at the accept edge.
- rsp_rdata and rsp_err are registered at accept. They stay stable while rsp_valid=1 and rsp_ready=0.
- Read-only registers hold no storage. Reads of them never return RESET_VAL.

## Timing
- While rst=1:
  - All read/write registers are set to RESET_VAL.
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0, gated by rst.
  - Requests are ignored.
- First cycle after rst falls: req_ready=1.
- Latency: accept at edge N gives rsp_valid=1 in cycle N+1. The write is visible to a read accepted at edge N+2 or later.
- Response handshake at edge M gives req_ready=1 in cycle M+1. There is no same-cycle turnaround. Peak throughput is one access per 2 cycles.
- req_ready does not depend combinationally on rsp_ready.
- Reset asserted while in RESP: the response is dropped and rsp_valid=0 at the next edge. Pending write effects already applied are overwritten by RESET_VAL.
- Request inputs are don't-care when req_valid=0.
- hw_status is sampled only at the accept edge.

## Structure
- Package reg_bank_pkg holds:
  - State enum (ST_IDLE, ST_RESP).
  - Error-decode helper function.
  - Byte-merge function (old, new, strb).
- Sub-module reg_bank_cell is one DATA_W register with synchronous reset to RESET_VAL and a strobed write-enable. It is generated for each i with RO_MASK[i]=0.
- Top holds the FSM, address/error decode, the read mux over cells and hw_status slices, and the response registers.

## Test plan
- Reset then read every address 0..7 -> addresses 0..6 return 0 with err=0; address 7 returns hw_status[255:224]=32'hCAFE_F00D with err=0.
- Write addr 2 data 32'h1122_3344 strb 4'b0101, then read 2 -> rdata 32'h0022_0044, both err=0.
- Write addr 7 (read-only) and read addr 9 (out of range) -> err=1 and rdata=0 for both; a following read of addr 7 still returns hw_status.
- Read addr 1 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata are stable, req_ready=0 throughout; req_ready=1 one cycle after the handshake.
- Write addr 0 data 32'hFFFF_FFFF, assert rst during RESP -> rsp_valid=0 next cycle; after reset, read addr 0 returns 0.
- Back-to-back requests with rsp_ready=1 constantly -> accepts occur every 2nd cycle; a write to addr 3 followed by a read of addr 3 returns the new value.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the reg_bank_hs register target.
//   state_e     - two-state request/response FSM encoding
//   access_err  - decides whether an accepted access is an error
//   byte_merge  - merges new bytes into an old word under a byte strobe
// byte_merge works on a fixed maximum width (MERGE_W); callers widen their
// operands into it and truncate the result back to their own width.
package reg_bank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam int unsigned MERGE_W      = 256;
  localparam int unsigned MERGE_STRB_W = MERGE_W / 8;

  // Out-of-range accesses and writes to read-only slots are errors.
  function automatic logic access_err(input logic in_range,
                                      input logic is_wr,
                                      input logic is_ro);
    return !in_range || (is_wr && is_ro);
  endfunction

  function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]      old_v,
      input logic [MERGE_W-1:0]      new_v,
      input logic [MERGE_STRB_W-1:0] strb);
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(MERGE_STRB_W); b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one DATA_W read/write register with byte-strobed write.
//   clk, rst  - clock, synchronous active-high reset (loads RESET_VAL)
//   we_i      - write enable for this cell (already qualified by decode)
//   wdata_i   - write data
//   strb_i    - byte enables; bytes with strobe 0 keep their value
//   q_o       - current register value
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   strb_i,
  output logic [DATA_W-1:0]     q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      q_d = DATA_W'(byte_merge(MERGE_W'(q_q), MERGE_W'(wdata_i),
                               MERGE_STRB_W'(strb_i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_bank_hs.sv
// reg_bank_hs: NUM_REGS-entry register bank behind a valid/ready request
// channel and a backpressurable response channel.
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake (req_ready low during rst)
//   req_wr, req_addr          - access type and register offset
//   req_wdata, req_strb       - write data and byte enables
//   hw_status                 - packed status; slice i backs read-only reg i
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata, rsp_err        - registered read data / error flag
// Read-only registers (RO_MASK bit set) have no storage; reads return the
// hw_status slice sampled at the accept edge.
module reg_bank_hs
  import reg_bank_pkg::*;
#(
  parameter int                  NUM_REGS  = 8,
  parameter int                  DATA_W    = 32,
  parameter int                  ADDR_W    = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK   = 8'h80,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err
);

  state_e            state_q, state_d;
  logic              accept, in_range, ro_hit, err;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] cell_q [NUM_REGS];
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // req_ready is a pure function of state and rst, never of rsp_ready.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(NUM_REGS);

  always_comb begin
    ro_hit = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        ro_hit = RO_MASK[i];
        rd_sel = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : cell_q[i];
      end
    end
  end

  assign err = access_err(in_range, req_wr, ro_hit);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign cell_q[g] = '0;
    end else begin : g_rw
      reg_bank_cell #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && req_wr && !err && (req_addr == ADDR_W'(g))),
        .wdata_i (req_wdata),
        .strb_i  (req_strb),
        .q_o     (cell_q[g])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Response payload is captured only at accept and held until handshake.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_err_d   = err;
      rsp_rdata_d = (!req_wr && !err) ? rd_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bank_hs.sv
module tb_reg_bank_hs;

  localparam int          NUM_REGS = 8;
  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 4;
  localparam logic [7:0]  RO_MASK  = 8'h80;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        req_valid, req_ready, req_wr;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic [DATA_W/8-1:0]         req_strb;
  logic [NUM_REGS*DATA_W-1:0]  hw_status;
  logic                        rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0]           rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0]  model [NUM_REGS];
  int unsigned  cyc = 0;
  int unsigned  acc_cyc [$];
  logic [32:0]  rsp_log [$];

  always #5 clk = ~clk;

  reg_bank_hs #(
    .NUM_REGS (NUM_REGS), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
    .RO_MASK  (RO_MASK),  .RESET_VAL ('0)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_wr (req_wr),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_strb (req_strb),
    .hw_status (hw_status),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc.push_back(cyc);
    if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_err, rsp_rdata});
  end

  // Reference model: registers as a plain array, rules applied in accept order.
  function automatic void model_access(input logic wr, input logic [3:0] a,
                                       input logic [31:0] wd, input logic [3:0] st,
                                       output logic [31:0] er, output logic ee);
    er = '0;
    ee = 1'b0;
    if (a >= NUM_REGS) ee = 1'b1;
    else if (wr && RO_MASK[a[2:0]]) ee = 1'b1;
    else if (wr) begin
      for (int b = 0; b < 4; b++) if (st[b]) model[a[2:0]][8*b +: 8] = wd[8*b +: 8];
    end else if (RO_MASK[a[2:0]]) er = hw_status[a[2:0]*32 +: 32];
    else er = model[a[2:0]];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endfunction

  task automatic access(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; req_strb = st;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    rd = rsp_rdata;
    e  = rsp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd, er;
    logic e, ee;
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd0;
    req_wdata = 32'hFFFF_FFFF; req_strb = 4'hF;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_ready: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
    for (int a = 0; a < NUM_REGS; a++) begin
      model_access(1'b0, 4'(a), '0, '0, er, ee);
      access(1'b0, 4'(a), '0, '0, rd, e);
      total++;
      if (rd !== er || e !== ee || (a == 7 && rd !== 32'hCAFE_F00D)) begin
        bad++;
        $display("FAIL reset_read addr=%0d: rdata=%h err=%b required %h %b", a, rd, e, er, ee);
      end
    end
  endtask

  task automatic test_strobe_write();
    logic [31:0] rd, er;
    logic e, ee;
    model_access(1'b1, 4'd2, 32'h1122_3344, 4'b0101, er, ee);
    access(1'b1, 4'd2, 32'h1122_3344, 4'b0101, rd, e);
    total++;
    if (rd !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL strobe_write_rsp: rdata=%h err=%b required 0 0", rd, e);
    end
    model_access(1'b0, 4'd2, '0, '0, er, ee);
    access(1'b0, 4'd2, '0, '0, rd, e);
    total++;
    if (rd !== 32'h0022_0044 || e !== 1'b0 || er !== 32'h0022_0044) begin
      bad++; $display("FAIL strobe_readback: rdata=%h err=%b required 00220044 0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, er;
    logic e, ee;
    model_access(1'b1, 4'd7, 32'h1234_5678, 4'hF, er, ee);
    access(1'b1, 4'd7, 32'h1234_5678, 4'hF, rd, e);
    total++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      bad++; $display("FAIL ro_write_err: rdata=%h err=%b required 0 1", rd, e);
    end
    model_access(1'b0, 4'd9, '0, '0, er, ee);
    access(1'b0, 4'd9, '0, '0, rd, e);
    total++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      bad++; $display("FAIL oor_read_err: rdata=%h err=%b required 0 1", rd, e);
    end
    model_access(1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF, er, ee);
    access(1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF, rd, e);
    total++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      bad++; $display("FAIL oor_write_err: rdata=%h err=%b required 0 1", rd, e);
    end
    model_access(1'b0, 4'd7, '0, '0, er, ee);
    access(1'b0, 4'd7, '0, '0, rd, e);
    total++;
    if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
      bad++; $display("FAIL ro_read_after_write: rdata=%h err=%b required cafef00d 0", rd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, er;
    logic e, ee;
    int n;
    model_access(1'b1, 4'd1, 32'h5A5A_A5A5, 4'hF, er, ee);
    access(1'b1, 4'd1, 32'h5A5A_A5A5, 4'hF, rd, e);
    model_access(1'b0, 4'd1, '0, '0, er, ee);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h 0 0",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready, er);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd, er;
    logic e, ee;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd0;
    req_wdata = 32'hFFFF_FFFF; req_strb = 4'hF;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL resp_before_reset: valid=%b required 1", rsp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_resp: valid=%b ready=%b required 0 0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    model_access(1'b0, 4'd0, '0, '0, er, ee);
    access(1'b0, 4'd0, '0, '0, rd, e);
    total++;
    if (rd !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL read_after_reset_in_resp: rdata=%h err=%b required 0 0", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] wd_t [4] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_1234, 32'h0};
    logic [3:0]  st_t [4] = '{4'hF, 4'h0, 4'b0011, 4'h0};
    logic [32:0] exp_q [$];
    logic [31:0] er;
    logic ee;
    int n;
    acc_cyc.delete();
    rsp_log.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr_t[k]; req_addr = 4'd3;
      req_wdata = wd_t[k]; req_strb = st_t[k];
      model_access(wr_t[k], 4'd3, wd_t[k], st_t[k], er, ee);
      exp_q.push_back({ee, er});
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (acc_cyc.size() !== 4 || rsp_log.size() !== 4) begin
      bad++;
      $display("FAIL b2b_counts: accepts=%0d responses=%0d required 4 4", acc_cyc.size(), rsp_log.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (acc_cyc[k] - acc_cyc[k-1] !== 2) begin
          bad++;
          $display("FAIL b2b_spacing k=%0d: gap=%0d required 2", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rsp_log[k] !== exp_q[k]) begin
          bad++;
          $display("FAIL b2b_rsp k=%0d: got=%h required %h", k, rsp_log[k], exp_q[k]);
        end
      end
      total++;
      if (rsp_log[1][31:0] !== 32'hDEAD_BEEF || rsp_log[3][31:0] !== 32'hDEAD_1234) begin
        bad++;
        $display("FAIL b2b_readback: rd1=%h rd3=%h required deadbeef dead1234",
                 rsp_log[1][31:0], rsp_log[3][31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, wd;
    logic e, ee, wr;
    logic [3:0] a, st;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      hw_status[7*32 +: 32] = $urandom;
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 9));
      wd = $urandom;
      st = 4'($urandom);
      model_access(wr, a, wd, st, er, ee);
      access(wr, a, wd, st, rd, e);
      total++;
      if (rd !== er || e !== ee) begin
        bad++;
        $display("FAIL random k=%0d wr=%b addr=%0d: rdata=%h err=%b required %h %b",
                 k, wr, a, rd, e, er, ee);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) hw_status[i*32 +: 32] = $urandom;
    hw_status[7*32 +: 32] = 32'hCAFE_F00D;
    test_reset();
    test_strobe_write();
    test_errors();
    test_backpressure();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
